alu_share_arb: RTL and testbench

- Shares one 16-bit ALU datapath between two requesters (e.g. execute stage and address-generation/branch-compare logic).
- Round-robin arbitration; valid/ready request handshake; registered ALU operands; registered result+flags held until consumed.
- Sits between the requesters and a single ALU instance; drives its op/operand inputs and samples its result and z/v/n flags.

---
 rtl/alu_share_arb.sv | 104 ++++++++++
 tb/tb_alu_share_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU between two valid/ready requesters.
// Define ALU_SHARE_ARB_STATS_EN to enable the saturating per-requester grant counters.
module alu_share_arb #(
    parameter int WIDTH = 16,
    parameter int OPW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    output logic [15:0]      gnt0_cnt,
    output logic [15:0]      gnt1_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nx;
    logic   rr, owner, gnt1, hs0, hs1, hs, take;

    // rr=1 gives requester 1 priority when both are valid
    assign gnt1 = req1_valid & (~req0_valid | rr);
    assign hs0  = req0_valid & req0_ready;
    assign hs1  = req1_valid & req1_ready;
    assign hs   = hs0 | hs1;
    assign take = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (hs ? EXEC : IDLE) :
                   (state == EXEC) ? RESP : (take ? IDLE : RESP);

    always_comb begin
        req0_ready = ~rst & (state == IDLE) & req0_valid & ~gnt1;
        req1_ready = ~rst & (state == IDLE) & gnt1;
        rsp0_valid = (state == RESP) & ~owner;
        rsp1_valid = (state == RESP) & owner;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            owner      <= 1'b0;
            rr         <= 1'b0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_n      <= 1'b0;
        end else begin
            if (hs) begin
                alu_op <= gnt1 ? req1_op : req0_op;
                alu_a  <= gnt1 ? req1_a : req0_a;
                alu_b  <= gnt1 ? req1_b : req0_b;
                owner  <= gnt1;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_z      <= alu_z;
                rsp_v      <= alu_v;
                rsp_n      <= alu_n;
            end
            if (take) rr <= ~owner;
        end

`ifdef ALU_SHARE_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (hs0 && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
            if (hs1 && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
        end
`else
    assign gnt0_cnt = '0;
    assign gnt1_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench; expected grant counts follow ALU_SHARE_ARB_STATS_EN.
module tb_alu_share_arb;
    logic        clk, rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op, alu_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_z, rsp_v, rsp_n, alu_z, alu_v, alu_n;
    logic [15:0] gnt0_cnt, gnt1_cnt;
    int          checks = 0;
    int          failures = 0;

    alu_share_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU
    always_comb begin
        alu_result = 16'h0;
        alu_v = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_result = alu_a + alu_b;
                alu_v = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            3'd1: begin
                alu_result = alu_a - alu_b;
                alu_v = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            3'd2: alu_result = ~(alu_a & alu_b);
            3'd3: alu_result = alu_a ^ alu_b;
            3'd4: alu_result = alu_a + 16'd1;
            3'd5: alu_result = $signed(alu_a) >>> alu_b[3:0];
            3'd6: alu_result = alu_a >> alu_b[3:0];
            default: alu_result = alu_a << alu_b[3:0];
        endcase
        alu_z = (alu_result == 16'h0);
        alu_n = alu_result[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
        {req0_op, req1_op} = '0;
        {req0_a, req0_b, req1_a, req1_b} = '0;
        tick();
        tick();
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b[12:0]}, 0);
        chk("rst_rsp", {rsp_result, rsp_z, rsp_v, rsp_n}, 0);
        chk("rst_cnt", {gnt0_cnt, gnt1_cnt}, 0);
        rst = 1'b0;

        // single request: ADD 3+4
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0003; req0_b = 16'h0004; rsp0_ready = 1'b1;
        #1;
        chk("single_ready", {30'd0, req0_ready, req1_ready}, 32'h2);
        tick();
        req0_valid = 1'b0;
        chk("single_alu", {alu_op, alu_a, alu_b[12:0]}, {3'd0, 16'h0003, 13'h0004});
        chk("single_exec_valid", {31'd0, rsp0_valid}, 0);
        tick();
        chk("single_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'h2);
        chk("single_rsp", {rsp_result, rsp_z, rsp_v, rsp_n}, {16'h0007, 3'b000});
        tick();
        chk("single_done", {31'd0, rsp0_valid}, 0);

        // contention from reset: grants 0,1,0
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h0005; req0_b = 16'h0005;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 16'hFFFF; req1_b = 16'h00FF;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("cont_g0", {30'd0, req0_ready, req1_ready}, 32'h2);
        tick();
        tick();
        chk("cont_rsp0_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'h2);
        chk("cont_rsp0", {rsp_result, rsp_z, rsp_v, rsp_n}, {16'h0000, 3'b100});
        tick();
        chk("cont_g1", {30'd0, req0_ready, req1_ready}, 32'h1);
        tick();
        tick();
        chk("cont_rsp1_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'h1);
        chk("cont_rsp1", {rsp_result, rsp_z, rsp_v, rsp_n}, {16'hFF00, 3'b001});
        tick();
        chk("cont_g2", {30'd0, req0_ready, req1_ready}, 32'h2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

        // back-pressure on requester 1 with requester 0 waiting
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h7FFF; req1_b = 16'h0001;
        #1;
        chk("bp_g1", {30'd0, req0_ready, req1_ready}, 32'h1);
        tick();
        req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 3'd4; req0_a = 16'h0010;
        rsp0_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'h1);
            chk("bp_rsp", {rsp_result, rsp_z, rsp_v, rsp_n}, {16'h8000, 3'b011});
            chk("bp_req0_ready", {31'd0, req0_ready}, 0);
            tick();
        end
        rsp1_ready = 1'b1;
        tick();
        chk("bp_release", {30'd0, rsp1_valid, req0_ready}, 32'h1);
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        tick();

        // withdrawn request during RESP
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0001;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("wd_rsp", {14'd0, rsp0_valid, rsp_result}, {14'd0, 1'b1, 16'h0002});
        req0_valid = 1'b1; req0_a = 16'h0009;
        #1;
        chk("wd_ready", {31'd0, req0_ready}, 0);
        tick();
        req0_valid = 1'b0; rsp0_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wd_no_extra", {30'd0, rsp0_valid, rsp1_valid}, 0);
            chk("wd_alu_a", {16'd0, alu_a}, 32'h0001);
            tick();
        end

        // reset during EXEC with requester 1 pending
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0002; req0_b = 16'h0002;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_op = 3'd4; req1_a = 16'h0010; req1_b = 16'h0000;
        rst = 1'b1;
        #1;
        chk("mid_rst_alu", {alu_op, alu_a, alu_b[12:0]}, 0);
        chk("mid_rst_valid", {28'd0, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
        tick();
        rst = 1'b0;
        rsp1_ready = 1'b1;
        #1;
        chk("post_rst_g1", {30'd0, req0_ready, req1_ready}, 32'h1);
        tick();
        req1_valid = 1'b0;
        chk("post_rst_no_rsp0", {31'd0, rsp0_valid}, 0);
        tick();
        chk("post_rst_rsp1", {15'd0, rsp1_valid, rsp_result}, {15'd0, 1'b1, 16'h0011});

        // grant counting: 0,1,0,1,0 from reset
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 16'hF0F0; req0_b = 16'hFF00;
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 16'h8000; req1_b = 16'h0004;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_SHARE_ARB_STATS_EN
        chk("cnt", {gnt0_cnt, gnt1_cnt}, {16'd3, 16'd2});
`else
        chk("cnt", {gnt0_cnt, gnt1_cnt}, 0);
`endif
        chk("cnt_last_alu", {alu_op, alu_a, alu_b[12:0]}, {3'd2, 16'hF0F0, 13'h1F00});
        chk("cnt_last_rsp", {rsp_result, rsp_z, rsp_v, rsp_n}, {16'h0FFF, 3'b000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
